// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_if
//  Description : Operand/result bundle for the 16-bit sign-magnitude ALU.
//                master drives the operation (func_c, in_fc, in1_m2, in2_m7)
//                and receives the results (op, out_r0, out_flag, out_oflw);
//                slave is the ALU side.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_if;
    logic [3:0]  func_c;    // operation code, used when in_fc = 00
    logic [1:0]  in_fc;     // 00 execute, 01 compare, 10 move, 11 hold
    logic [15:0] in1_m2;    // operand A, sign-magnitude
    logic [15:0] in2_m7;    // operand B, sign-magnitude
    logic [15:0] op;        // primary result
    logic [15:0] out_r0;    // secondary result, bit 15 always 0
    logic        out_flag;  // zero / equal flag
    logic        out_oflw;  // overflow / illegal-operation flag

    modport master (
        output func_c, in_fc, in1_m2, in2_m7,
        input  op, out_r0, out_flag, out_oflw
    );

    modport slave (
        input  func_c, in_fc, in1_m2, in2_m7,
        output op, out_r0, out_flag, out_oflw
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 16-bit sign-magnitude ALU, one-cycle registered latency,
//                one operation accepted every cycle.
//  Ports       : clk  - clock, outputs registered on rising edge
//                rst  - asynchronous active-high reset, clears all outputs
//                bus  - alu_if.slave: func_c, in_fc, in1_m2, in2_m7 in;
//                       op, out_r0, out_flag, out_oflw out
//  Options     : ALU_DIV_EN - when defined a divider is built for func_c 0101;
//                otherwise 0101 reports an illegal operation (out_oflw = 1).
//  Revision    : 1.0  initial release
// ============================================================================
module alu (
    input  wire logic clk,
    input  wire logic rst,
    alu_if.slave      bus
);
    localparam logic [1:0] c_FC_EXEC = 2'b00;
    localparam logic [1:0] c_FC_CMP  = 2'b01;
    localparam logic [1:0] c_FC_MOVE = 2'b10;

    localparam logic [3:0] c_ADD = 4'h0;
    localparam logic [3:0] c_SUB = 4'h1;
    localparam logic [3:0] c_AND = 4'h2;
    localparam logic [3:0] c_OR  = 4'h3;
    localparam logic [3:0] c_MUL = 4'h4;
    localparam logic [3:0] c_DIV = 4'h5;
    localparam logic [3:0] c_XOR = 4'h6;
    localparam logic [3:0] c_NOT = 4'h7;
    localparam logic [3:0] c_SHL = 4'h8;
    localparam logic [3:0] c_SHR = 4'h9;
    localparam logic [3:0] c_INC = 4'hA;
    localparam logic [3:0] c_DEC = 4'hB;

    logic        w_sa, w_sb;
    logic [14:0] w_ma, w_mb;
    assign w_sa = bus.in1_m2[15];
    assign w_ma = bus.in1_m2[14:0];
    assign w_sb = bus.in2_m7[15];
    assign w_mb = bus.in2_m7[14:0];

    // ADD/SUB/INC/DEC share one sign-magnitude adder: SUB flips B's sign,
    // INC/DEC replace B with +1/-1.
    logic        w_add_sb;
    logic [14:0] w_add_mb;
    always_comb begin
        w_add_sb = w_sb;
        w_add_mb = w_mb;
        case (bus.func_c)
            c_SUB:   w_add_sb = ~w_sb;
            c_INC:   begin w_add_sb = 1'b0; w_add_mb = 15'd1; end
            c_DEC:   begin w_add_sb = 1'b1; w_add_mb = 15'd1; end
            default: ;
        endcase
    end

    logic [15:0] w_add_sum;
    logic [14:0] w_sub_ab, w_sub_ba;
    logic        w_a_ge_b;
    assign w_add_sum = {1'b0, w_ma} + {1'b0, w_add_mb};
    assign w_sub_ab  = w_ma - w_add_mb;
    assign w_sub_ba  = w_add_mb - w_ma;
    assign w_a_ge_b  = (w_ma >= w_add_mb);

    // Like signs add magnitudes (may carry out); unlike signs subtract the
    // smaller magnitude from the larger and take the larger one's sign.
    logic        w_add_sign, w_add_ovf;
    logic [14:0] w_add_mag;
    always_comb begin
        w_add_sign = w_sa;
        w_add_mag  = w_add_sum[14:0];
        w_add_ovf  = w_add_sum[15];
        if (w_sa != w_add_sb) begin
            w_add_ovf = 1'b0;
            if (w_a_ge_b) begin
                w_add_sign = w_sa;
                w_add_mag  = w_sub_ab;
            end else begin
                w_add_sign = w_add_sb;
                w_add_mag  = w_sub_ba;
            end
        end
    end

    logic [29:0] w_prod;
    assign w_prod = 30'(w_ma) * 30'(w_mb);

`ifdef ALU_DIV_EN
    // Quotient is forced to 0 on divide-by-zero so the result normalizes to +0;
    // the remainder output then carries |A|.
    logic        w_div0;
    logic [14:0] w_quo, w_rem;
    assign w_div0 = (w_mb == 15'd0);
    assign w_quo  = w_div0 ? 15'd0 : (w_ma / w_mb);
    assign w_rem  = w_div0 ? w_ma  : (w_ma % w_mb);
`endif

    // Numeric values for compare; -0 and +0 both map to 0.
    logic signed [15:0] w_va, w_vb;
    assign w_va = w_sa ? -$signed({1'b0, w_ma}) : $signed({1'b0, w_ma});
    assign w_vb = w_sb ? -$signed({1'b0, w_mb}) : $signed({1'b0, w_mb});

    logic [15:0] r_op, r_r0;
    logic        r_flag, r_oflw;

    logic [15:0] w_res, w_op_nxt, w_r0_nxt;
    logic        w_flag_nxt, w_oflw_nxt;
    always_comb begin
        w_res      = 16'h0000;
        w_op_nxt   = 16'h0000;
        w_r0_nxt   = 16'h0000;
        w_flag_nxt = 1'b0;
        w_oflw_nxt = 1'b0;
        case (bus.in_fc)
            c_FC_EXEC: begin
                case (bus.func_c)
                    c_ADD, c_SUB, c_INC, c_DEC: begin
                        w_res      = {w_add_sign, w_add_mag};
                        w_oflw_nxt = w_add_ovf;
                    end
                    c_MUL: begin
                        w_res      = {w_sa ^ w_sb, w_prod[14:0]};
                        w_r0_nxt   = {1'b0, w_prod[29:15]};
                        w_oflw_nxt = |w_prod[29:15];
                    end
                    c_DIV: begin
`ifdef ALU_DIV_EN
                        w_res      = {w_sa ^ w_sb, w_quo};
                        w_r0_nxt   = {1'b0, w_rem};
                        w_oflw_nxt = w_div0;
`else
                        w_oflw_nxt = 1'b1;
`endif
                    end
                    c_AND:   w_res = bus.in1_m2 & bus.in2_m7;
                    c_OR:    w_res = bus.in1_m2 | bus.in2_m7;
                    c_XOR:   w_res = bus.in1_m2 ^ bus.in2_m7;
                    c_NOT:   w_res = ~bus.in1_m2;
                    c_SHL:   w_res = bus.in1_m2 << bus.in2_m7[3:0];
                    c_SHR:   w_res = bus.in1_m2 >> bus.in2_m7[3:0];
                    default: ;
                endcase
                // A zero magnitude is always reported as +0.
                w_op_nxt   = (w_res[14:0] == 15'd0) ? 16'h0000 : w_res;
                w_flag_nxt = (w_op_nxt == 16'h0000);
            end
            c_FC_CMP: begin
                w_flag_nxt = (w_va == w_vb);
                w_r0_nxt   = {15'd0, (w_va < w_vb)};
            end
            c_FC_MOVE: begin
                w_op_nxt   = (w_mb == 15'd0) ? 16'h0000 : bus.in2_m7;
                w_flag_nxt = (w_op_nxt == 16'h0000);
            end
            default: begin
                w_op_nxt   = r_op;
                w_r0_nxt   = r_r0;
                w_flag_nxt = r_flag;
                w_oflw_nxt = r_oflw;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= 16'h0000;
            r_r0   <= 16'h0000;
            r_flag <= 1'b0;
            r_oflw <= 1'b0;
        end else begin
            r_op   <= w_op_nxt;
            r_r0   <= w_r0_nxt;
            r_flag <= w_flag_nxt;
            r_oflw <= w_oflw_nxt;
        end
    end

    assign bus.op       = r_op;
    assign bus.out_r0   = r_r0;
    assign bus.out_flag = r_flag;
    assign bus.out_oflw = r_oflw;
endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Randomized bench for alu with a queue-based scoreboard and an
//                integer-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu;
    logic clk = 1'b0;
    logic rst;

    alu_if bus();

    alu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] op;
        logic [15:0] r0;
        logic        flag;
        logic        oflw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference-model architectural state (needed for hold).
    logic [15:0] m_op, m_r0;
    logic        m_flag, m_oflw;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sm2int(input logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    // Build a result from sign and magnitude: magnitude truncated to 15 bits,
    // zero magnitude always positive.
    function automatic logic [15:0] pack(input bit neg, input int mag);
        int m;
        m = mag % 32768;
        if (m == 0) return 16'h0000;
        return {neg, 15'(m)};
    endfunction

    function automatic logic [15:0] norm(input logic [15:0] v);
        return (v[14:0] == 15'd0) ? 16'h0000 : v;
    endfunction

    task automatic model_arith(input int r);
        int mag;
        mag    = (r < 0) ? -r : r;
        m_op   = pack(r < 0, mag);
        m_oflw = (mag > 32767);
    endtask

    task automatic model_step(input logic [1:0] fc, input logic [3:0] fn,
                              input logic [15:0] a, input logic [15:0] b);
        int ia, ib, ma, mb, p;
        ia = sm2int(a);
        ib = sm2int(b);
        ma = int'(a[14:0]);
        mb = int'(b[14:0]);
        case (fc)
            2'b11: ;
            2'b01: begin
                m_op   = 16'h0000;
                m_flag = (ia == ib);
                m_r0   = (ia < ib) ? 16'h0001 : 16'h0000;
                m_oflw = 1'b0;
            end
            2'b10: begin
                m_op   = norm(b);
                m_r0   = 16'h0000;
                m_oflw = 1'b0;
                m_flag = (m_op == 16'h0000);
            end
            default: begin
                m_op   = 16'h0000;
                m_r0   = 16'h0000;
                m_oflw = 1'b0;
                case (fn)
                    4'h0: model_arith(ia + ib);
                    4'h1: model_arith(ia - ib);
                    4'hA: model_arith(ia + 1);
                    4'hB: model_arith(ia - 1);
                    4'h4: begin
                        p      = ma * mb;
                        m_op   = pack(a[15] ^ b[15], p);
                        m_r0   = 16'(p / 32768);
                        m_oflw = (p >= 32768);
                    end
                    4'h5: begin
`ifdef ALU_DIV_EN
                        if (mb == 0) begin
                            m_r0   = 16'(ma);
                            m_oflw = 1'b1;
                        end else begin
                            m_op = pack(a[15] ^ b[15], ma / mb);
                            m_r0 = 16'(ma % mb);
                        end
`else
                        m_oflw = 1'b1;
`endif
                    end
                    4'h2: m_op = norm(a & b);
                    4'h3: m_op = norm(a | b);
                    4'h6: m_op = norm(a ^ b);
                    4'h7: m_op = norm(~a);
                    4'h8: m_op = norm(a << b[3:0]);
                    4'h9: m_op = norm(a >> b[3:0]);
                    default: ;
                endcase
                m_flag = (m_op == 16'h0000);
            end
        endcase
    endtask

    task automatic drive(input logic [1:0] fc, input logic [3:0] fn,
                         input logic [15:0] a, input logic [15:0] b);
        bus.in_fc  = fc;
        bus.func_c = fn;
        bus.in1_m2 = a;
        bus.in2_m7 = b;
    endtask

    task automatic issue_now(input logic [1:0] fc, input logic [3:0] fn,
                             input logic [15:0] a, input logic [15:0] b);
        drive(fc, fn, a, b);
        model_step(fc, fn, a, b);
        exp_q.push_back('{op: m_op, r0: m_r0, flag: m_flag, oflw: m_oflw});
    endtask

    task automatic issue(input logic [1:0] fc, input logic [3:0] fn,
                         input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        issue_now(fc, fn, a, b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_op"},   bus.op,   16'h0000);
        chk({tag, "_r0"},   bus.out_r0, 16'h0000);
        chk({tag, "_flag"}, {15'd0, bus.out_flag}, 16'h0000);
        chk({tag, "_oflw"}, {15'd0, bus.out_oflw}, 16'h0000);
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'hFFFF;
            4:       return {1'($urandom), 15'($urandom_range(0, 20))};
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: results are visible one edge after issue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("op",   bus.op,     e.op);
                chk("r0",   bus.out_r0, e.r0);
                chk("flag", {15'd0, bus.out_flag}, {15'd0, e.flag});
                chk("oflw", {15'd0, bus.out_oflw}, {15'd0, e.oflw});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] fc;
        rst    = 1'b1;
        m_op   = 16'h0000;
        m_r0   = 16'h0000;
        m_flag = 1'b0;
        m_oflw = 1'b0;
        drive(2'b11, 4'h0, 16'h0000, 16'h0000);
        #2;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        issue(2'b00, 4'h5, 16'h8014, 16'h0009);
        issue(2'b00, 4'h5, 16'h0014, 16'h0010);
        issue(2'b00, 4'h4, 16'h7FFF, 16'h0002);
        issue(2'b00, 4'h5, 16'h0005, 16'h8000);
        issue(2'b00, 4'h0, 16'h0005, 16'h8005);
        issue(2'b01, 4'h0, 16'h8000, 16'h0000);
        issue(2'b01, 4'h0, 16'h8003, 16'h0002);
        issue(2'b00, 4'h0, 16'h7FFF, 16'h0001);
        issue(2'b00, 4'hB, 16'h0000, 16'h0000);
        issue(2'b00, 4'h8, 16'h1234, 16'h0000);
        issue(2'b00, 4'h9, 16'h8001, 16'h000F);
        issue(2'b00, 4'hC, 16'h1234, 16'h5678);
        issue(2'b10, 4'h0, 16'h1234, 16'h8000);

        // Asynchronous reset after a MUL, then an operation discarded by reset
        issue(2'b00, 4'h4, 16'h800B, 16'h0008);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(negedge clk);
        drive(2'b00, 4'h4, 16'h7FFF, 16'h7FFF);
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        @(negedge clk);
        rst    = 1'b0;
        m_op   = 16'h0000;
        m_r0   = 16'h0000;
        m_flag = 1'b0;
        m_oflw = 1'b0;
        issue_now(2'b00, 4'h4, 16'h800B, 16'h0008);
        issue(2'b11, 4'h0, 16'h0001, 16'h0001);
        issue(2'b11, 4'h4, 16'h7FFF, 16'h7FFF);
        issue(2'b11, 4'h1, 16'h0000, 16'h8000);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            fc = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            issue(fc, 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
        end

        @(negedge clk);
        drive(2'b11, 4'h0, 16'h0000, 16'h0000);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits, sign-magnitude (bit 15 = sign, bits 14:0 = magnitude).
REQ-002 clk  input  1  sole clock; all outputs registered on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 func_c  input  4  operation code, used when in_fc = 00.
REQ-005 in_fc  input  2  function class: 00 execute func_c, 01 compare, 10 move, 11 hold.
REQ-006 in1_m2  input  16  operand A, sign-magnitude.
REQ-007 in2_m7  input  16  operand B, sign-magnitude.
REQ-008 op  output  16  primary result (quotient or low product for MUL/DIV).
REQ-009 out_r0  output  16  secondary result (remainder or high product), bit 15 always 0.
REQ-010 out_flag  output  1  zero/equal flag.
REQ-011 out_oflw  output  1  overflow / illegal-operation flag.

Function
REQ-012 Latency: exactly 1 clock; inputs sampled at a rising edge appear on all outputs after that edge; no handshake; a new operation is accepted every cycle.
REQ-013 func_c codes, in_fc = 00: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 MUL, 0101 DIV, 0110 XOR, 0111 NOT A, 1000 SHL A by B[3:0], 1001 SHR A by B[3:0], 1010 INC A, 1011 DEC A; 1100-1111 give op = 0, out_r0 = 0, out_flag = 1, out_oflw = 0.
REQ-014 ADD/SUB/INC/DEC: sign-magnitude arithmetic; magnitude carry beyond 15 bits sets out_oflw = 1, op = truncated 15-bit magnitude with computed sign; out_r0 = 0.
REQ-015 MUL: sign = A[15] XOR B[15]; 30-bit magnitude product; op = {sign, product[14:0]}; out_r0 = {0, product[29:15]}; out_oflw = 1 when product[29:15] is nonzero.
REQ-016 DIV: op = {A[15] XOR B[15], |A| / |B|}; out_r0 = {0, |A| mod |B|} (remainder magnitude, always positive); out_oflw = 0.
REQ-017 DIV by zero magnitude: op = 0, out_r0 = {0, |A|}, out_oflw = 1.
REQ-018 Logical/shift ops act on all 16 raw bits, zero-fill, out_r0 = 0, out_oflw = 0; shift amount 0 passes A unchanged.
REQ-019 Negative zero never appears on op: a zero magnitude result always has sign 0.
REQ-020 out_flag = 1 when op is all-zero after normalization, for all in_fc = 00 codes.
REQ-021 in_fc = 01 (compare): op = 0; out_flag = 1 when A == B numerically (+0 equals -0); out_r0 = 1 when A < B numerically, else 0; out_oflw = 0.
REQ-022 in_fc = 10 (move): op = B with -0 normalized to +0; out_r0 = 0; out_flag per REQ-020; out_oflw = 0.
REQ-023 in_fc = 11 (hold): all outputs retain their previous values.

Reset
REQ-024 rst high clears op, out_r0, out_flag and out_oflw to 0 immediately, independent of clk.
REQ-025 rst asserted mid-operation discards that operation; the first operation after deassertion is sampled at the next rising edge with rst low.

Configuration
REQ-026 Macro ALU_DIV_EN defined: DIV (func_c 0101) implemented per REQ-016/017.
REQ-027 ALU_DIV_EN undefined: no divider synthesized; func_c 0101 yields op = 0, out_r0 = 0, out_flag = 1, out_oflw = 1.

Verification
REQ-028 DIV: A=0x8014 (-20), B=0x0009, in_fc=00 -> op=0x8002, out_r0=0x0002, out_flag=0, out_oflw=0.
REQ-029 DIV: A=0x0014, B=0x0010 -> op=0x0001, out_r0=0x0004; with ALU_DIV_EN undefined -> op=0, out_r0=0, out_flag=1, out_oflw=1.
REQ-030 MUL: A=0x800B (-11), B=0x0008 -> op=0x8058, out_r0=0x0000, out_oflw=0; A=0x7FFF, B=0x0002 -> op=0x7FFE, out_r0=0x0001, out_oflw=1.
REQ-031 DIV by zero: A=0x0005, B=0x8000 -> op=0x0000, out_r0=0x0005, out_oflw=1.
REQ-032 ADD: A=0x0005, B=0x8005 -> op=0x0000 (no -0), out_flag=1; compare A=0x8000, B=0x0000 -> out_flag=1, out_r0=0.
REQ-033 Reset: assert rst between clock edges after a MUL -> all outputs 0 immediately; in_fc=11 for 3 cycles -> outputs unchanged.
